multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Central FSM that sequences the multicycle 16-bit CPU datapath (PC, instruction memory, register file, ALU, data memory) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Replaces the free-running enable juggling with a single clocked controller. It latches the opcode, picks the per-opcode state path, and stretches FETCH and MEMORY on memory handshakes.
- It drives the enable strobes and counts retired instructions.

Parameters:
- OP_W, 4, opcode width (instruction bits [15:12]).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = execute instructions, 0 = park in IDLE at the next instruction boundary.
- instr_op  input  OP_W  opcode from instruction memory output; valid when im_ready=1.
- im_ready  input  1  instruction memory has valid data this cycle.
- dm_ready  input  1  data memory access completes this cycle.
- im_req  output  1  instruction fetch request.
- ir_we  output  1  load instruction register / decode fields.
- rf_we  output  1  register file write strobe.
- dm_re  output  1  data memory read request.
- dm_we  output  1  data memory write request.
- pc_we  output  1  load next_pc into the PC.
- state_o  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5.
- op_o  output  OP_W  latched opcode of the instruction in flight.
- instr_done  output  1  one-cycle pulse, same cycle as the final pc_we of an instruction.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, immediate): state=IDLE, op_o=0, retired=0. All strobes and instr_done are 0 while rst=1 and in IDLE.
- Reset mid-instruction aborts it: no pc_we, and retired is not incremented.
- Outputs decode from registered state, latched op and the ready inputs. No strobe is ever asserted in IDLE.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH: im_req=1. Stay while im_ready=0. In the cycle with im_ready=1: ir_we=1, op latched from instr_op, next state DECODE.
- Opcode classes and state paths (pc_we + instr_done asserted in the last listed state):
  - R-type 0000-0010 and ALU-imm 0011-0100: F D E W; rf_we in W.
  - Loads 0101, 0110: F D E M W; dm_re in M; rf_we in W.
  - Store 0111: F D E M; dm_we in M; completes in the M cycle with dm_ready=1.
  - Branches 1000-1011: F D E; pc_we in E regardless of branch outcome (PC mux decides target).
  - JMP 1100 and RET 1110: F D; pc_we in D.
  - CALL 1101: F D W; rf_we in W (R7 link).
  - SV 1111: F D M; dm_we in M; completes with dm_ready.
- MEMORY: dm_re/dm_we held high every cycle until dm_ready=1; the state advances only on dm_ready. If dm_ready=1 on entry, MEMORY lasts 1 cycle.
- DECODE, EXECUTE and WRITEBACK always last exactly 1 cycle.
- Instruction boundary: after the completing state, next state is FETCH if run=1, else IDLE.
- run=0 mid-instruction never truncates it.
- retired increments by 1 on each instr_done and wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
- At most one of rf_we, dm_re, dm_we, pc_we is high in any cycle. The exceptions are W of R/ALU-imm/load/CALL and completing M of store/SV, where pc_we coincides.
- Unreachable state encodings (6, 7) return to IDLE on the next clock with all strobes 0.

Test Plan:
1. rst=1 then release with run=1, im_ready=1, instr_op=0001 (ADD) → state_o 1,2,3,5; ir_we in cycle 1; rf_we and pc_we and instr_done only in cycle 4; retired=1; cycle 5 back in FETCH.
2. LW 0101, dm_ready low for 3 cycles → MEMORY held 4 cycles with dm_re=1 throughout; rf_we/pc_we only in the following WRITEBACK; total 8 cycles.
3. JMP 1100 then SW 0111 with dm_ready=1 → JMP: F,D with pc_we in D (2 cycles). SW: F,D,E,M with dm_we and pc_we in M; rf_we never asserted.
4. im_ready low 2 cycles in FETCH of CALL 1101 → im_req held 3 cycles, ir_we only on the 3rd; then D, W with rf_we+pc_we.
5. Drop run during EXECUTE of BEQ 1000 → pc_we in E, then IDLE with all strobes 0. Raise run → FETCH next cycle.
6. Preload retired=0xFFFF (run 65535 JMPs, or force) then one more instruction → retired=0x0000. Assert rst in MEMORY of a load → IDLE immediately, no pc_we, retired unchanged.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Central controller for the multicycle 16-bit datapath. It walks each
// instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK on a per-opcode
// path, stretches FETCH and MEMORY on the memory handshakes, drives the
// datapath enable strobes and counts retired instructions.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE  (0) | parked, no strobes; leaves for FETCH when run=1
// FETCH (1) | im_req held until im_ready; then ir_we and the opcode is latched
// DECODE(2) | JMP/RET complete here; CALL -> WRITEBACK; SV -> MEMORY
// EXEC  (3) | branches complete here; loads/store -> MEMORY; ALU -> WRITEBACK
// MEMORY(4) | dm_re/dm_we held until dm_ready; store/SV complete here
// WB    (5) | rf_we with the final pc_we of the instruction
module multicycle_sequencer #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [OP_W-1:0]  instr_op,
   input  logic             im_ready,
   input  logic             dm_ready,
   output logic             im_req,
   output logic             ir_we,
   output logic             rf_we,
   output logic             dm_re,
   output logic             dm_we,
   output logic             pc_we,
   output logic [2:0]       state_o,
   output logic [OP_W-1:0]  op_o,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5
   } state_t;

   state_t          state_q;
   state_t          state_d;
   state_t          boundary;
   logic [OP_W-1:0] op_q;

   logic is_load;
   logic is_store;
   logic is_branch;
   logic is_jump;
   logic is_call;
   logic is_sv;

   // opcode classes of the instruction in flight
   always_comb begin
      is_load   = (op_q == OP_W'(5)) || (op_q == OP_W'(6));
      is_store  = (op_q == OP_W'(7));
      is_branch = (op_q >= OP_W'(8)) && (op_q <= OP_W'(11));
      is_jump   = (op_q == OP_W'(12)) || (op_q == OP_W'(14));
      is_call   = (op_q == OP_W'(13));
      is_sv     = (op_q == OP_W'(15));
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // opcode latch, loaded together with the instruction register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        op_q <= '0;
      else if (ir_we) op_q <= instr_op;
   end

   // retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             retired <= '0;
      else if (instr_done) retired <= retired + CNT_W'(1);
   end

   // next state and strobes; the completing state also picks FETCH or IDLE
   always_comb begin
      state_d    = state_q;
      boundary   = run ? S_FETCH : S_IDLE;
      im_req     = 1'b0;
      ir_we      = 1'b0;
      rf_we      = 1'b0;
      dm_re      = 1'b0;
      dm_we      = 1'b0;
      pc_we      = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            im_req = 1'b1;
            if (im_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_jump) begin
               pc_we      = 1'b1;
               instr_done = 1'b1;
               state_d    = boundary;
            end else if (is_call) begin
               state_d = S_WRITEBACK;
            end else if (is_sv) begin
               state_d = S_MEMORY;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (is_branch) begin
               pc_we      = 1'b1;
               instr_done = 1'b1;
               state_d    = boundary;
            end else if (is_load || is_store) begin
               state_d = S_MEMORY;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            if (is_load) begin
               dm_re = 1'b1;
               if (dm_ready) state_d = S_WRITEBACK;
            end else if (is_store || is_sv) begin
               dm_we = 1'b1;
               if (dm_ready) begin
                  pc_we      = 1'b1;
                  instr_done = 1'b1;
                  state_d    = boundary;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITEBACK: begin
            rf_we      = 1'b1;
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = boundary;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign state_o = state_q;
   assign op_o    = op_q;

endmodule
